// File: rtl/tensor_operand_join_pkg.sv
// rtl/tensor_operand_join_pkg.sv - shared constants, FSM encoding and tlast rule for the operand join
package tensor_operand_join_pkg;

  localparam int TILE_BEATS = 8;
  localparam int BEAT_W     = $clog2(TILE_BEATS);
  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 6;
  localparam int WID_W_DEF  = 3;

  localparam int IRQ_DONE = 0;
  localparam int IRQ_ERR  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } join_state_t;

  // Head tlast flags must all be clear before the final beat and all set on it.
  function automatic logic tlast_error(input logic [BEAT_W-1:0] beat, input logic [2:0] lasts);
    if (beat == BEAT_W'(TILE_BEATS - 1)) begin
      return lasts != 3'b111;
    end
    return lasts != 3'b000;
  endfunction

endpackage

// File: rtl/tensor_operand_join_if.sv
// rtl/tensor_operand_join_if.sv - operand streams, issue port, tags and irq bundle
interface tensor_operand_join_if
  import tensor_operand_join_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int WID_W  = WID_W_DEF
);

  logic              en;
  logic [TAG_W-1:0]  ctrl_reg_idxw_i;
  logic [WID_W-1:0]  ctrl_wid_i;
  logic [1:0]        irq_en;

  logic [DATA_W-1:0] s_axis_tdata_a, s_axis_tdata_b, s_axis_tdata_c;
  logic              s_axis_tvalid_a, s_axis_tvalid_b, s_axis_tvalid_c;
  logic              s_axis_tlast_a, s_axis_tlast_b, s_axis_tlast_c;
  logic              s_axis_tready_a, s_axis_tready_b, s_axis_tready_c;

  logic [DATA_W-1:0] op_a_o, op_b_o, op_c_o;
  logic              op_valid_o;
  logic              op_ready_i;
  logic              op_last_o;
  logic [BEAT_W-1:0] op_beat_o;
  logic [TAG_W-1:0]  reg_idxw_o;
  logic [WID_W-1:0]  warp_id_o;
  logic              busy;
  logic [1:0]        irq;

  modport slave (
    input  en, ctrl_reg_idxw_i, ctrl_wid_i, irq_en,
    input  s_axis_tdata_a, s_axis_tdata_b, s_axis_tdata_c,
    input  s_axis_tvalid_a, s_axis_tvalid_b, s_axis_tvalid_c,
    input  s_axis_tlast_a, s_axis_tlast_b, s_axis_tlast_c,
    output s_axis_tready_a, s_axis_tready_b, s_axis_tready_c,
    output op_a_o, op_b_o, op_c_o, op_valid_o, op_last_o, op_beat_o,
    input  op_ready_i,
    output reg_idxw_o, warp_id_o, busy, irq
  );

  modport master (
    output en, ctrl_reg_idxw_i, ctrl_wid_i, irq_en,
    output s_axis_tdata_a, s_axis_tdata_b, s_axis_tdata_c,
    output s_axis_tvalid_a, s_axis_tvalid_b, s_axis_tvalid_c,
    output s_axis_tlast_a, s_axis_tlast_b, s_axis_tlast_c,
    input  s_axis_tready_a, s_axis_tready_b, s_axis_tready_c,
    input  op_a_o, op_b_o, op_c_o, op_valid_o, op_last_o, op_beat_o,
    output op_ready_i,
    input  reg_idxw_o, warp_id_o, busy, irq
  );

endinterface

// File: rtl/tc_skid_fifo.sv
// rtl/tc_skid_fifo.sv - 2-entry operand skid buffer with registered head and ready
module tc_skid_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr_valid,
  input  logic [W-1:0] wr_data,
  input  logic         rd_pop,
  output logic         ready,
  output logic         nempty,
  output logic [W-1:0] head
);

  logic [W-1:0] tail;
  logic [1:0]   count;
  logic [1:0]   count_nx;

  always_comb begin
    count_nx = count;
    case ({wr_valid, rd_pop})
      2'b10:   count_nx = count + 2'd1;
      2'b01:   count_nx = count - 2'd1;
      default: count_nx = count;
    endcase
    if (flush) begin
      count_nx = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      ready <= 1'b0;
      head  <= '0;
      tail  <= '0;
    end else begin
      count <= count_nx;
      ready <= (count_nx != 2'd2);
      if (!flush) begin
        // A write lands in the head slot whenever that slot is free after this cycle's pop.
        if (wr_valid) begin
          if (count == 2'd0 || (count == 2'd1 && rd_pop)) begin
            head <= wr_data;
          end else begin
            tail <= wr_data;
          end
        end
        if (rd_pop && count == 2'd2) begin
          head <= tail;
        end
      end
    end
  end

  assign nempty = (count != 2'd0);

endmodule

// File: rtl/tensor_operand_join.sv
// rtl/tensor_operand_join.sv - joins A/B/C operand streams into aligned per-tile triples
module tensor_operand_join
  import tensor_operand_join_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int WID_W  = WID_W_DEF
) (
  input logic                   clk,
  input logic                   rst,
  tensor_operand_join_if.slave  bus
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(TILE_BEATS - 1);

  join_state_t       state;
  logic [BEAT_W-1:0] beat;
  logic [TAG_W-1:0]  reg_idxw;
  logic [WID_W-1:0]  warp_id;
  logic [1:0]        irq_q;

  logic [2:0]        fifo_ready;
  logic [2:0]        fifo_nempty;
  logic [DATA_W:0]   head_a, head_b, head_c;
  logic [2:0]        head_lasts;
  logic              in_err;
  logic              flush;
  logic              op_valid;
  logic              xfer;

  assign in_err     = (state == ST_ERR);
  assign flush      = in_err & ~bus.en;
  assign op_valid   = (state == ST_RUN) & (&fifo_nempty);
  assign xfer       = op_valid & bus.op_ready_i;
  assign head_lasts = {head_c[DATA_W], head_b[DATA_W], head_a[DATA_W]};

  assign bus.s_axis_tready_a = fifo_ready[0] & ~in_err;
  assign bus.s_axis_tready_b = fifo_ready[1] & ~in_err;
  assign bus.s_axis_tready_c = fifo_ready[2] & ~in_err;

  tc_skid_fifo #(.W(DATA_W + 1)) u_fifo_a (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_valid (bus.s_axis_tvalid_a & bus.s_axis_tready_a),
    .wr_data  ({bus.s_axis_tlast_a, bus.s_axis_tdata_a}),
    .rd_pop   (xfer),
    .ready    (fifo_ready[0]),
    .nempty   (fifo_nempty[0]),
    .head     (head_a)
  );

  tc_skid_fifo #(.W(DATA_W + 1)) u_fifo_b (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_valid (bus.s_axis_tvalid_b & bus.s_axis_tready_b),
    .wr_data  ({bus.s_axis_tlast_b, bus.s_axis_tdata_b}),
    .rd_pop   (xfer),
    .ready    (fifo_ready[1]),
    .nempty   (fifo_nempty[1]),
    .head     (head_b)
  );

  tc_skid_fifo #(.W(DATA_W + 1)) u_fifo_c (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_valid (bus.s_axis_tvalid_c & bus.s_axis_tready_c),
    .wr_data  ({bus.s_axis_tlast_c, bus.s_axis_tdata_c}),
    .rd_pop   (xfer),
    .ready    (fifo_ready[2]),
    .nempty   (fifo_nempty[2]),
    .head     (head_c)
  );

  // The offending triple of a misaligned tile is still consumed before entering ERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      beat     <= '0;
      reg_idxw <= '0;
      warp_id  <= '0;
      irq_q    <= '0;
    end else begin
      irq_q <= '0;
      case (state)
        ST_IDLE: begin
          if (bus.en) begin
            state    <= ST_RUN;
            beat     <= '0;
            reg_idxw <= bus.ctrl_reg_idxw_i;
            warp_id  <= bus.ctrl_wid_i;
          end
        end
        ST_RUN: begin
          if (xfer) begin
            if (tlast_error(beat, head_lasts)) begin
              state          <= ST_ERR;
              beat           <= '0;
              irq_q[IRQ_ERR] <= bus.irq_en[IRQ_ERR];
            end else if (beat == LAST_BEAT) begin
              state           <= ST_DONE;
              beat            <= '0;
              irq_q[IRQ_DONE] <= bus.irq_en[IRQ_DONE];
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_ERR: begin
          if (!bus.en) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.op_a_o     = head_a[DATA_W-1:0];
  assign bus.op_b_o     = head_b[DATA_W-1:0];
  assign bus.op_c_o     = head_c[DATA_W-1:0];
  assign bus.op_valid_o = op_valid;
  assign bus.op_last_o  = op_valid & (beat == LAST_BEAT);
  assign bus.op_beat_o  = beat;
  assign bus.reg_idxw_o = reg_idxw;
  assign bus.warp_id_o  = warp_id;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.irq        = irq_q;

endmodule

// File: tb/tb_tensor_operand_join.sv
// tb/tb_tensor_operand_join.sv - randomized bench for tensor_operand_join against a queue model
module tb_tensor_operand_join;
  import tensor_operand_join_pkg::*;

  localparam int DW = 32;
  localparam int TW = 6;
  localparam int WW = 3;

  typedef struct packed {
    logic [DW-1:0]     a;
    logic [DW-1:0]     b;
    logic [DW-1:0]     c;
    logic [BEAT_W-1:0] beat;
  } trip_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tensor_operand_join_if #(.DATA_W(DW), .TAG_W(TW), .WID_W(WW)) bus ();

  tensor_operand_join #(.DATA_W(DW), .TAG_W(TW), .WID_W(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  trip_t         exp_q[$];
  int            xfer_cyc[$];
  logic [TW-1:0] exp_tag = '0;
  logic [WW-1:0] exp_wid = '0;
  logic [DW:0]   stim[3][TILE_BEATS];
  int            n_beats[3];
  int            must[3];
  int            dly[3];
  int            gap_pct = 0;
  int            rdy_mode = 0;
  bit            abort = 1'b0;
  int            cyc = 0;
  int            xfer_cnt = 0;
  int            done_cnt = 0;
  int            err_cnt = 0;
  bit            stall_pending = 1'b0;
  logic [3*DW+BEAT_W:0] stall_snap;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int s, input logic v, input logic [DW:0] d);
    case (s)
      0: begin bus.s_axis_tvalid_a = v; {bus.s_axis_tlast_a, bus.s_axis_tdata_a} = d; end
      1: begin bus.s_axis_tvalid_b = v; {bus.s_axis_tlast_b, bus.s_axis_tdata_b} = d; end
      default: begin bus.s_axis_tvalid_c = v; {bus.s_axis_tlast_c, bus.s_axis_tdata_c} = d; end
    endcase
  endtask

  function automatic logic get_ready(input int s);
    case (s)
      0: return bus.s_axis_tready_a;
      1: return bus.s_axis_tready_b;
      default: return bus.s_axis_tready_c;
    endcase
  endfunction

  // Reference: stream beats are issued in order, one triple per tile beat, beat index = position.
  task automatic build(input int err_beat);
    int nt;
    nt = (err_beat < 0) ? TILE_BEATS : err_beat + 1;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < TILE_BEATS; i++) begin
        stim[s][i] = {(i == TILE_BEATS - 1), DW'($urandom)};
      end
      n_beats[s] = (s == 0 || err_beat < 0) ? TILE_BEATS : nt;
      must[s] = nt;
    end
    if (err_beat >= 0) stim[2][err_beat][DW] = 1'b1;
    for (int i = 0; i < nt; i++) begin
      exp_q.push_back({stim[0][i][DW-1:0], stim[1][i][DW-1:0], stim[2][i][DW-1:0], BEAT_W'(i)});
    end
  endtask

  task automatic new_tags();
    exp_tag = exp_tag ^ TW'($urandom_range(1, (1 << TW) - 1));
    exp_wid = exp_wid ^ WW'($urandom_range(1, (1 << WW) - 1));
    bus.ctrl_reg_idxw_i = exp_tag;
    bus.ctrl_wid_i = exp_wid;
  endtask

  task automatic drive(input int s);
    @(posedge clk); #1;
    repeat (dly[s]) begin @(posedge clk); #1; end
    for (int i = 0; i < n_beats[s]; i++) begin
      bit ok;
      int waited;
      ok = 1'b0;
      waited = 0;
      while (!abort && gap_pct != 0 && $urandom_range(99) < gap_pct) begin @(posedge clk); #1; end
      if (abort) break;
      set_in(s, 1'b1, stim[s][i]);
      while (!ok && !abort && waited < 100) begin
        @(negedge clk);
        ok = get_ready(s);
        @(posedge clk); #1;
        waited++;
      end
      set_in(s, 1'b0, '0);
      if (!ok) begin
        if (!abort && i < must[s]) check("accept_timeout", 128'(ok), 128'(1));
        break;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 128'(bus.op_valid_o), 128'(0));
    check({tag, "_busy"}, 128'(bus.busy), 128'(0));
    check({tag, "_irq"}, 128'(bus.irq), 128'(0));
    check({tag, "_beat_last"}, 128'({bus.op_beat_o, bus.op_last_o}), 128'(0));
    check({tag, "_tags"}, 128'({bus.reg_idxw_o, bus.warp_id_o}), 128'(0));
    check({tag, "_tready"}, 128'({bus.s_axis_tready_a, bus.s_axis_tready_b, bus.s_axis_tready_c}), 128'(0));
    check({tag, "_ops"}, 128'({bus.op_a_o, bus.op_b_o, bus.op_c_o}), 128'(0));
  endtask

  task automatic run_tile(input int gap, input int dly_b, input int err_beat,
                          input logic [1:0] ien, input bit consec);
    int d0, e0;
    bit seen;
    new_tags();
    bus.irq_en = ien;
    bus.en = 1'b1;
    abort = 1'b0;
    gap_pct = gap;
    d0 = done_cnt;
    e0 = err_cnt;
    xfer_cyc.delete();
    build(err_beat);
    dly[0] = 0; dly[1] = dly_b; dly[2] = 0;
    fork
      drive(0);
      drive(1);
      drive(2);
      begin
        if (dly_b >= 5 && gap == 0) begin
          repeat (5) @(negedge clk);
          check("a_backpressure", 128'(bus.s_axis_tready_a), 128'(0));
          check("wait_for_b", 128'(bus.op_valid_o), 128'(0));
        end
      end
    join
    if (err_beat < 0) begin
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
        @(negedge clk);
        seen = !bus.busy;
      end
      check("tile_end", 128'(seen), 128'(1));
      check("done_irq", 128'(done_cnt - d0), 128'(ien[0]));
      check("no_err_irq", 128'(err_cnt - e0), 128'(0));
      check("all_triples", 128'(exp_q.size()), 128'(0));
      if (consec) begin
        if (xfer_cyc.size() == TILE_BEATS) check("consecutive", 128'(xfer_cyc[TILE_BEATS-1] - xfer_cyc[0]), 128'(TILE_BEATS - 1));
        else check("consecutive_cnt", 128'(xfer_cyc.size()), 128'(TILE_BEATS));
      end
    end else begin
      @(negedge clk);
      check("err_irq", 128'(err_cnt - e0), 128'(ien[1]));
      check("err_busy", 128'(bus.busy), 128'(1));
      check("err_tready", 128'({bus.s_axis_tready_a, bus.s_axis_tready_b, bus.s_axis_tready_c}), 128'(0));
      check("err_no_valid", 128'(bus.op_valid_o), 128'(0));
      check("err_triples", 128'(exp_q.size()), 128'(0));
      bus.en = 1'b0;
      @(negedge clk);
      check("err_exit", 128'(bus.busy), 128'(0));
      check("flushed_ready", 128'({bus.s_axis_tready_a, bus.s_axis_tready_b, bus.s_axis_tready_c}), 128'(7));
    end
  endtask

  task automatic run_reset_tile();
    int x0;
    new_tags();
    bus.irq_en = 2'b01;
    bus.en = 1'b1;
    abort = 1'b0;
    gap_pct = 0;
    x0 = xfer_cnt;
    build(-1);
    dly[0] = 0; dly[1] = 0; dly[2] = 0;
    fork
      drive(0);
      drive(1);
      drive(2);
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge clk); #1;
          if (xfer_cnt - x0 >= 5) break;
        end
        check("reached_beat4", 128'(xfer_cnt - x0), 128'(5));
        abort = 1'b1;
        rst = 1'b1;
        bus.en = 1'b0;
        @(negedge clk);
        check_zero("midtile_reset");
        exp_q.delete();
        rst = 1'b0;
      end
    join
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    trip_t t;
    cyc++;
    if (rst) begin
      stall_pending = 1'b0;
    end else begin
      if (bus.irq[IRQ_DONE]) done_cnt++;
      if (bus.irq[IRQ_ERR]) err_cnt++;
      if (stall_pending)
        check("stall_hold", 128'({bus.op_valid_o, bus.op_a_o, bus.op_b_o, bus.op_c_o, bus.op_beat_o}), 128'(stall_snap));
      stall_pending = 1'b0;
      if (bus.op_valid_o && bus.op_ready_i) begin
        xfer_cnt++;
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("extra_triple", 128'(1), 128'(0));
        end else begin
          t = exp_q.pop_front();
          check("triple", 128'({bus.op_a_o, bus.op_b_o, bus.op_c_o}), 128'({t.a, t.b, t.c}));
          check("beat", 128'(bus.op_beat_o), 128'(t.beat));
          check("last", 128'(bus.op_last_o), 128'(t.beat == BEAT_W'(TILE_BEATS - 1)));
          check("tags", 128'({bus.reg_idxw_o, bus.warp_id_o}), 128'({exp_tag, exp_wid}));
        end
      end else if (bus.op_valid_o) begin
        stall_pending = 1'b1;
        stall_snap = {bus.op_valid_o, bus.op_a_o, bus.op_b_o, bus.op_c_o, bus.op_beat_o};
      end
    end
  end

  initial begin
    bus.op_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.op_ready_i = 1'b1;
        1: bus.op_ready_i = ~bus.op_ready_i;
        default: bus.op_ready_i = ($urandom_range(99) < 60);
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en = 1'b0;
    bus.irq_en = 2'b00;
    bus.ctrl_reg_idxw_i = '0;
    bus.ctrl_wid_i = '0;
    for (int s = 0; s < 3; s++) set_in(s, 1'b0, '0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    rdy_mode = 0;
    run_tile(0, 0, -1, 2'b01, 1'b1);
    run_tile(0, 5, -1, 2'b11, 1'b0);
    rdy_mode = 1;
    run_tile(0, 0, -1, 2'b01, 1'b0);
    rdy_mode = 2;
    repeat (4) run_tile(30, $urandom_range(0, 3), -1, 2'b01, 1'b0);
    rdy_mode = 0;
    run_tile(0, 0, 3, 2'b11, 1'b0);
    run_tile(0, 0, -1, 2'b01, 1'b0);
    run_reset_tile();
    run_tile(0, 0, -1, 2'b00, 1'b0);
    rdy_mode = 2;
    run_tile(20, 1, -1, 2'b01, 1'b0);
    run_tile(0, 0, -1, 2'b01, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
